// File: rtl/rv_debug_ctrl.sv
// rv_debug_ctrl: command/response debug port (halt, resume, N-step, reg/imem peek, status) for the Mini-RISC-V core
// Ports: clk/Rst (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_arg command channel;
//        rsp_valid/rsp_ready/rsp_data/rsp_err response channel; core_halt stall out, core_retire pulse in;
//        reg_sel/reg_addr/reg_rdata register-file peek; imem_en/imem_addr/imem_rdata instruction-memory peek
module rv_debug_ctrl #(
   parameter int XLEN = 32,
   parameter int REG_AW = 5,
   parameter int IMEM_AW = 12,
   parameter int STEP_W = 8,
   parameter int DRAIN_CYCLES = 4,
   parameter int HALT_ON_RESET = 0
) (
   input  logic               clk,
   input  logic               Rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [XLEN-1:0]    cmd_arg,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [XLEN-1:0]    rsp_data,
   output logic               rsp_err,
   output logic               core_halt,
   input  logic               core_retire,
   output logic [REG_AW-1:0]  reg_addr,
   output logic               reg_sel,
   input  logic [XLEN-1:0]    reg_rdata,
   output logic               imem_en,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [XLEN-1:0]    imem_rdata
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   typedef enum logic [2:0] {RUN, DRAIN, HALTED, STEP, READ, CAPT, RESP} state_t;
   state_t state;
   logic [31:0] retire_cnt;
   logic [STEP_W-1:0] step_n, step_cnt;
   logic [XLEN-1:0] step_acc;
   logic [DW-1:0] drain_cnt;
   logic is_step, rd_imem, halted, unused;
   assign halted = state == HALTED;
   assign unused = ^{cmd_arg, retire_cnt[31:16]};
   function automatic logic [XLEN-1:0] status(input logic h);
      return XLEN'({retire_cnt[15:0], 15'd0, h});
   endfunction
   always_ff @(posedge clk) begin
      if (!Rst) begin
         state <= HALT_ON_RESET != 0 ? HALTED : RUN;
         core_halt <= HALT_ON_RESET != 0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_err <= 1'b0;
         reg_sel <= 1'b0;
         reg_addr <= '0;
         imem_en <= 1'b0;
         imem_addr <= '0;
         retire_cnt <= '0;
         step_n <= '0;
         step_cnt <= '0;
         step_acc <= '0;
         drain_cnt <= '0;
         is_step <= 1'b0;
         rd_imem <= 1'b0;
      end else begin
         retire_cnt <= retire_cnt + 32'(core_retire);
         case (state)
            RUN, HALTED: if (cmd_valid && cmd_ready) begin
               // default is an immediate response; multi-cycle ops override below
               cmd_ready <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err <= 1'b0;
               rsp_data <= '0;
               state <= RESP;
               case (cmd_op)
                  3'd0: if (halted) rsp_data <= status(1'b1);
                  else begin
                     core_halt <= 1'b1;
                     rsp_valid <= 1'b0;
                     is_step <= 1'b0;
                     drain_cnt <= DW'(DRAIN_CYCLES - 1);
                     state <= DRAIN;
                  end
                  3'd1: begin
                     core_halt <= 1'b0;
                     rsp_data <= status(1'b0);
                  end
                  3'd2: if (!halted) rsp_err <= 1'b1;
                  else if (cmd_arg[STEP_W-1:0] != '0) begin
                     rsp_valid <= 1'b0;
                     core_halt <= 1'b0;
                     step_n <= cmd_arg[STEP_W-1:0];
                     step_cnt <= '0;
                     step_acc <= '0;
                     is_step <= 1'b1;
                     state <= STEP;
                  end
                  3'd3, 3'd4: if (!halted) rsp_err <= 1'b1;
                  else begin
                     rsp_valid <= 1'b0;
                     rd_imem <= cmd_op[2];
                     reg_sel <= !cmd_op[2];
                     imem_en <= cmd_op[2];
                     if (cmd_op[2]) imem_addr <= cmd_arg[IMEM_AW-1:0];
                     else reg_addr <= cmd_arg[REG_AW-1:0];
                     state <= READ;
                  end
                  3'd5: rsp_data <= status(halted);
                  default: rsp_err <= 1'b1;
               endcase
            end
            STEP: if (core_retire) begin
               step_cnt <= step_cnt + STEP_W'(1);
               step_acc <= step_acc + XLEN'(1);
               if (step_cnt + STEP_W'(1) == step_n) begin
                  core_halt <= 1'b1;
                  drain_cnt <= DW'(DRAIN_CYCLES - 1);
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // in-flight instructions still retire while draining and count toward the step result
               step_acc <= step_acc + XLEN'(core_retire);
               if (drain_cnt == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_err <= 1'b0;
                  rsp_data <= is_step ? step_acc + XLEN'(core_retire) : status(1'b1);
                  state <= RESP;
               end else drain_cnt <= drain_cnt - DW'(1);
            end
            READ: begin
               reg_sel <= 1'b0;
               imem_en <= 1'b0;
               state <= CAPT;
            end
            CAPT: begin
               rsp_data <= rd_imem ? imem_rdata : reg_rdata;
               rsp_valid <= 1'b1;
               rsp_err <= 1'b0;
               state <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state <= core_halt ? HALTED : RUN;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_rv_debug_ctrl.sv
// tb_rv_debug_ctrl: directed plus randomized checks of rv_debug_ctrl against a command-level reference model
module tb_rv_debug_ctrl;
   localparam int D = 4;
   logic clk = 1'b0;
   logic Rst = 1'b0;
   logic cmd_valid = 1'b0;
   logic rsp_ready = 1'b0;
   logic core_retire = 1'b0;
   logic [2:0] cmd_op = 3'd0;
   logic [31:0] cmd_arg = 32'd0;
   logic [31:0] reg_rdata, imem_rdata, rsp_data;
   logic cmd_ready, rsp_valid, rsp_err, core_halt, reg_sel, imem_en;
   logic [4:0] reg_addr;
   logic [11:0] imem_addr;
   int checks = 0;
   int errors = 0;
   logic [31:0] regs [32];
   logic [31:0] imem_m [4096];
   bit m_halted;
   logic [31:0] m_cnt;

   rv_debug_ctrl #(.XLEN(32), .REG_AW(5), .IMEM_AW(12), .STEP_W(8), .DRAIN_CYCLES(D), .HALT_ON_RESET(0)) dut (
      .clk(clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .core_halt(core_halt), .core_retire(core_retire), .reg_addr(reg_addr), .reg_sel(reg_sel),
      .reg_rdata(reg_rdata), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata));

   always #5 clk = ~clk;

   // register file and instruction memory both return data one cycle after the address
   always @(posedge clk) begin
      reg_rdata <= regs[reg_addr];
      if (imem_en) imem_rdata <= imem_m[imem_addr];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status(input bit h);
      return {m_cnt[15:0], 15'd0, h};
   endfunction

   task automatic tick(input logic r);
      core_retire = r;
      @(negedge clk);
      if (r) m_cnt++;
   endtask

   task automatic handshake(input int hold, input logic [31:0] exp_d, input logic exp_e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk1("hold_valid", rsp_valid, 1'b1);
         chk("hold_data", rsp_data, exp_d);
         chk1("hold_err", rsp_err, exp_e);
         chk1("hold_cmd_ready", cmd_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk1("done_valid", rsp_valid, 1'b0);
      chk1("done_cmd_ready", cmd_ready, 1'b1);
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [31:0] arg, input int exp_lat, input logic [31:0] exp_d,
                         input logic exp_e, input logic exp_h, input int hold, input bit early);
      int lat;
      chk1("cmd_ready_idle", cmd_ready, 1'b1);
      rsp_ready = early;
      cmd_op = op;
      cmd_arg = arg;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      chk1("halt_t1", core_halt, exp_h);
      while (!rsp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("rsp_data", rsp_data, exp_d);
      chk1("rsp_err", rsp_err, exp_e);
      chk1("halt_at_rsp", core_halt, exp_h);
      handshake(hold, exp_d, exp_e);
   endtask

   task automatic probe_read(input logic [2:0] op, input logic [31:0] arg, input logic [31:0] exp, input int hold, input bit early);
      chk1("rd_cmd_ready", cmd_ready, 1'b1);
      rsp_ready = early;
      cmd_op = op;
      cmd_arg = arg;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk1("rd_reg_sel", reg_sel, op == 3'd3);
      chk1("rd_imem_en", imem_en, op == 3'd4);
      if (op == 3'd3) chk("rd_reg_addr", 32'(reg_addr), 32'(arg[4:0]));
      else chk("rd_imem_addr", 32'(imem_addr), 32'(arg[11:0]));
      chk1("rd_halt", core_halt, 1'b1);
      chk1("rd_valid_t1", rsp_valid, 1'b0);
      @(negedge clk);
      chk1("rd_sel_off", reg_sel | imem_en, 1'b0);
      chk1("rd_valid_t2", rsp_valid, 1'b0);
      @(negedge clk);
      chk1("rd_valid_t3", rsp_valid, 1'b1);
      chk("rd_data", rsp_data, exp);
      chk1("rd_err", rsp_err, 1'b0);
      handshake(hold, exp, 1'b0);
   endtask

   // STEP from HALTED; pat supplies the retire pulse for each cycle after acceptance
   task automatic step_run(input logic [31:0] arg, input logic [63:0] pat, input int hold);
      int n, cnt, tot, k;
      logic r;
      n = int'(arg[7:0]);
      cnt = 0;
      tot = 0;
      k = 0;
      chk1("step_cmd_ready", cmd_ready, 1'b1);
      rsp_ready = 1'b0;
      cmd_op = 3'd2;
      cmd_arg = arg;
      cmd_valid = 1'b1;
      core_retire = 1'b1;
      @(negedge clk);
      m_cnt++;
      cmd_valid = 1'b0;
      chk1("step_halt_t1", core_halt, 1'b0);
      while (cnt < n && k < 200) begin
         r = pat[k % 64];
         k++;
         core_retire = r;
         @(negedge clk);
         if (r) begin
            cnt++;
            tot++;
            m_cnt++;
         end
         chk1("step_halt", core_halt, cnt == n);
         chk1("step_no_rsp", rsp_valid, 1'b0);
      end
      chk("step_reached", 32'(cnt), 32'(n));
      for (int i = 0; i < D; i++) begin
         r = pat[k % 64];
         k++;
         core_retire = r;
         @(negedge clk);
         if (r) begin
            tot++;
            m_cnt++;
         end
         chk1("drain_halt", core_halt, 1'b1);
         chk1("drain_valid", rsp_valid, i == D - 1);
      end
      core_retire = 1'b0;
      chk("step_data", rsp_data, 32'(tot));
      chk1("step_err", rsp_err, 1'b0);
      handshake(hold, 32'(tot), 1'b0);
   endtask

   task automatic model_cmd(input logic [2:0] op, input logic [31:0] arg, input int hold, input bit early);
      logic [63:0] pat;
      case (op)
         3'd0: begin
            do_cmd(op, arg, m_halted ? 1 : 1 + D, status(1'b1), 1'b0, 1'b1, hold, early);
            m_halted = 1'b1;
         end
         3'd1: begin
            do_cmd(op, arg, 1, status(1'b0), 1'b0, 1'b0, hold, early);
            m_halted = 1'b0;
         end
         3'd2: begin
            if (!m_halted) do_cmd(op, arg, 1, 32'd0, 1'b1, 1'b0, hold, early);
            else if (arg[7:0] == 8'd0) do_cmd(op, arg, 1, 32'd0, 1'b0, 1'b1, hold, early);
            else begin
               pat = {$urandom, $urandom} | 64'h1111_1111_1111_1111;
               step_run(arg, pat, hold);
            end
         end
         3'd3: if (!m_halted) do_cmd(op, arg, 1, 32'd0, 1'b1, 1'b0, hold, early);
               else probe_read(op, arg, regs[arg[4:0]], hold, early);
         3'd4: if (!m_halted) do_cmd(op, arg, 1, 32'd0, 1'b1, 1'b0, hold, early);
               else probe_read(op, arg, imem_m[arg[11:0]], hold, early);
         3'd5: do_cmd(op, arg, 1, status(m_halted), 1'b0, m_halted, hold, early);
         default: do_cmd(op, arg, 1, 32'd0, 1'b1, m_halted, hold, early);
      endcase
   endtask

   initial begin
      logic [2:0] op;
      logic [31:0] arg;
      bit early;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int i = 0; i < 4096; i++) imem_m[i] = $urandom;
      m_cnt = 32'd0;
      m_halted = 1'b0;
      repeat (3) @(negedge clk);
      chk1("reset_cmd_ready", cmd_ready, 1'b1);
      chk1("reset_core_halt", core_halt, 1'b0);
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk1("reset_rsp_err", rsp_err, 1'b0);
      chk("reset_rsp_data", rsp_data, 32'd0);
      chk1("reset_reg_sel", reg_sel, 1'b0);
      chk1("reset_imem_en", imem_en, 1'b0);
      Rst = 1'b1;
      @(negedge clk);
      do_cmd(3'd5, 32'd0, 1, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0);
      model_cmd(3'd0, 32'd0, 0, 1'b0);
      regs[10] = 32'hDEAD_BEEF;
      probe_read(3'd3, 32'hFFFF_FFEA, 32'hDEAD_BEEF, 0, 1'b0);
      probe_read(3'd4, 32'h1234_07FF, imem_m[12'h7FF], 0, 1'b0);
      model_cmd(3'd0, 32'd0, 0, 1'b0);
      step_run(32'hABCD_0003, 64'h1F, 0);
      model_cmd(3'd2, 32'h0000_0100, 0, 1'b0);
      model_cmd(3'd5, 32'd0, 10, 1'b0);
      model_cmd(3'd1, 32'd0, 0, 1'b0);
      model_cmd(3'd3, 32'd3, 0, 1'b0);
      model_cmd(3'd4, 32'd3, 0, 1'b0);
      model_cmd(3'd2, 32'd3, 0, 1'b0);
      model_cmd(3'd7, 32'd0, 10, 1'b0);
      model_cmd(3'd6, 32'd0, 0, 1'b1);
      model_cmd(3'd5, 32'd0, 0, 1'b1);
      model_cmd(3'd1, 32'd0, 0, 1'b1);
      for (int it = 0; it < 80; it++) begin
         op = 3'($urandom_range(0, 7));
         arg = $urandom;
         if (op == 3'd2) arg[7:0] = 8'($urandom_range(0, 6));
         early = 1'($urandom_range(0, 1));
         model_cmd(op, arg, early ? 0 : $urandom_range(0, 3), early);
      end
      model_cmd(3'd5, 32'd0, 0, 1'b0);
      if (!m_halted) model_cmd(3'd0, 32'd0, 0, 1'b0);
      chk1("pre_step_ready", cmd_ready, 1'b1);
      cmd_op = 3'd2;
      cmd_arg = 32'd5;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      core_retire = 1'b1;
      @(negedge clk);
      core_retire = 1'b0;
      @(negedge clk);
      Rst = 1'b0;
      @(negedge clk);
      Rst = 1'b1;
      m_cnt = 32'd0;
      m_halted = 1'b0;
      chk1("rst_step_halt", core_halt, 1'b0);
      chk1("rst_step_valid", rsp_valid, 1'b0);
      chk1("rst_step_ready", cmd_ready, 1'b1);
      repeat (6) @(negedge clk);
      chk1("rst_step_no_rsp", rsp_valid, 1'b0);
      model_cmd(3'd5, 32'd0, 0, 1'b0);
      cmd_op = 3'd0;
      cmd_arg = 32'd0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk1("drain_start_halt", core_halt, 1'b1);
      @(negedge clk);
      Rst = 1'b0;
      @(negedge clk);
      Rst = 1'b1;
      chk1("rst_drain_halt", core_halt, 1'b0);
      chk1("rst_drain_valid", rsp_valid, 1'b0);
      chk1("rst_drain_ready", cmd_ready, 1'b1);
      repeat (6) @(negedge clk);
      chk1("rst_drain_no_rsp", rsp_valid, 1'b0);
      for (int i = 0; i < 65539; i++) tick(1'b1);
      tick(1'b0);
      model_cmd(3'd5, 32'd0, 0, 1'b0);
      model_cmd(3'd0, 32'd0, 0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
